// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit universal shift register with a multi-cycle shift sequencer
// Per-edge hold/load/shift/rotate/asr/clear; start runs one shift mode for shamt cycles.
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CW-1:0]    shamt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] W_CW   = CW'(WIDTH);
  localparam logic [CW-1:0] CW_ONE = CW'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CW-1:0]    w_shamt_clamp;
  logic             w_mode_seq;

  function automatic logic [WIDTH-1:0] f_apply(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] dat,
    input logic             sl,
    input logic             sr
  );
    case (op)
      3'b001:  f_apply = dat;
      3'b010:  f_apply = {cur[WIDTH-2:0], sr};
      3'b011:  f_apply = {sl, cur[WIDTH-1:1]};
      3'b100:  f_apply = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  f_apply = {cur[0], cur[WIDTH-1:1]};
      3'b110:  f_apply = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'b111:  f_apply = '0;
      default: f_apply = cur;
    endcase
  endfunction

  assign w_shamt_clamp = (shamt > W_CW) ? W_CW : shamt;
  // Only the shift/rotate/asr modes are meaningful to repeat; others finish immediately.
  assign w_mode_seq    = (mode >= 3'b010) && (mode <= 3'b110);

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (en) begin
          if (start) begin
            w_op_nxt = mode;
            if (w_mode_seq && (w_shamt_clamp != '0)) begin
              w_cnt_nxt   = w_shamt_clamp;
              w_state_nxt = SHIFT;
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = DONE;
            end
          end else begin
            w_q_nxt = f_apply(mode, r_q, d, sin_l, sin_r);
          end
        end
      end
      SHIFT: begin
        if (en) begin
          w_q_nxt   = f_apply(r_op, r_q, d, sin_l, sin_r);
          w_cnt_nxt = r_cnt - CW_ONE;
          if (r_cnt == CW_ONE) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= RESET_VAL;
      r_op    <= 3'b000;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign q      = r_q;
  assign q_bar  = ~r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg
// Directed scenarios plus randomized stimulus against a behavioural model.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst, en, sin_l, sin_r, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] shamt;
  logic [7:0] q, q_bar;
  logic       sout_l, sout_r, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: remaining shifts, the op being repeated, a pending done pulse.
  logic [7:0] m_q    = 8'h00;
  int         m_rem  = 0;
  logic [2:0] m_op   = 3'b000;
  bit         m_done = 1'b0;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .start(start), .shamt(shamt), .q(q), .q_bar(q_bar), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f_ref(input logic [2:0] md, input logic [7:0] cur,
                                        input logic [7:0] dat, input logic sl, input logic sr);
    int v;
    v = int'(cur);
    case (md)
      3'd1:    v = int'(dat);
      3'd2:    v = (v * 2) % 256 + int'(sr);
      3'd3:    v = v / 2 + int'(sl) * 128;
      3'd4:    v = (v * 2) % 256 + v / 128;
      3'd5:    v = v / 2 + (v % 2) * 128;
      3'd6:    v = v / 2 + ((v >= 128) ? 128 : 0);
      3'd7:    v = 0;
      default: v = v;
    endcase
    return v[7:0];
  endfunction

  task automatic model_edge();
    int n;
    if (rst) begin
      m_q = 8'h00; m_rem = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      if (en) begin
        m_q = f_ref(m_op, m_q, d, sin_l, sin_r);
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end
    end else if (en) begin
      if (start) begin
        n = (int'(shamt) > 8) ? 8 : int'(shamt);
        if (mode >= 3'd2 && mode <= 3'd6 && n > 0) begin
          m_op = mode; m_rem = n;
        end else begin
          m_done = 1'b1;
        end
      end else begin
        m_q = f_ref(mode, m_q, d, sin_l, sin_r);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; en = 1'b1; mode = 3'd0; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    start = 1'b0; shamt = 4'd0;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'd1; d = v; tick(); mode = 3'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; mode = 3'd1; d = 8'hFF;
    tick(); tick();
    n_total++;
    if ({q, q_bar, busy, done} !== {8'h00, 8'hFF, 1'b0, 1'b0})
      $display("FAIL reset_state got q=%h q_bar=%h busy=%b done=%b exp 00 FF 0 0", q, q_bar, busy, done);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (q !== 8'hFF) $display("FAIL reset_release_load got %h exp FF", q); else n_pass++;
  endtask

  task automatic test_shl();
    idle_inputs();
    load(8'hA5);
    mode = 3'd2; sin_r = 1'b1; tick(); mode = 3'd0;
    n_total++;
    if ({q, q_bar, sout_l, sout_r} !== {8'h4B, 8'hB4, 1'b0, 1'b1})
      $display("FAIL shl_once got q=%h q_bar=%h sl=%b sr=%b exp 4B B4 0 1", q, q_bar, sout_l, sout_r);
    else n_pass++;
  endtask

  task automatic test_rotr_seq();
    logic [7:0] exp_q [4];
    exp_q = '{8'h81, 8'hC0, 8'h60, 8'h30};
    idle_inputs();
    load(8'h81);
    mode = 3'd5; shamt = 4'd3; start = 1'b1; tick();
    start = 1'b0; mode = 3'd0; shamt = 4'd0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({q, busy, done} !== {exp_q[i], (i < 3), (i == 3)})
        $display("FAIL rotr_seq step%0d got q=%h busy=%b done=%b exp %h %b %b",
                 i, q, busy, done, exp_q[i], (i < 3), (i == 3));
      else n_pass++;
      if (i < 3) tick();
    end
    tick();
    n_total++;
    if ({q, busy, done} !== {8'h30, 1'b0, 1'b0})
      $display("FAIL rotr_seq_idle got q=%h busy=%b done=%b exp 30 0 0", q, busy, done);
    else n_pass++;
  endtask

  task automatic test_stall();
    idle_inputs();
    load(8'h80);
    mode = 3'd6; shamt = 4'd2; start = 1'b1; tick();
    start = 1'b0; mode = 3'd0;
    tick();
    en = 1'b0; tick(); tick();
    n_total++;
    if ({q, busy, done} !== {8'hC0, 1'b1, 1'b0})
      $display("FAIL asr_stall got q=%h busy=%b done=%b exp C0 1 0", q, busy, done);
    else n_pass++;
    en = 1'b1; tick();
    n_total++;
    if ({q, busy, done} !== {8'hE0, 1'b0, 1'b1})
      $display("FAIL asr_done got q=%h busy=%b done=%b exp E0 0 1", q, busy, done);
    else n_pass++;
    tick();
  endtask

  task automatic test_zero_len();
    idle_inputs();
    load(8'h5A);
    mode = 3'd2; shamt = 4'd0; start = 1'b1; tick();
    n_total++;
    if ({q, busy, done} !== {8'h5A, 1'b0, 1'b1})
      $display("FAIL shamt0 got q=%h busy=%b done=%b exp 5A 0 1", q, busy, done);
    else n_pass++;
    start = 1'b0; tick();
    mode = 3'd1; d = 8'hFF; shamt = 4'd5; start = 1'b1; tick();
    start = 1'b0; mode = 3'd0;
    n_total++;
    if ({q, busy, done} !== {8'h5A, 1'b0, 1'b1})
      $display("FAIL start_load got q=%h busy=%b done=%b exp 5A 0 1", q, busy, done);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL done_single got %b exp 0", done); else n_pass++;
    mode = 3'd4; shamt = 4'd2; start = 1'b1; tick();
    mode = 3'd7; shamt = 4'd1;
    tick(); tick();
    start = 1'b0; mode = 3'd0;
    n_total++;
    if ({q, busy, done} !== {8'h69, 1'b0, 1'b1})
      $display("FAIL start_while_busy got q=%h busy=%b done=%b exp 69 0 1", q, busy, done);
    else n_pass++;
    tick();
    n_total++;
    if ({q, busy, done} !== {8'h69, 1'b0, 1'b0})
      $display("FAIL no_queued_start got q=%h busy=%b done=%b exp 69 0 0", q, busy, done);
    else n_pass++;
  endtask

  task automatic test_abort_clamp();
    idle_inputs();
    load(8'hA5);
    mode = 3'd2; shamt = 4'd4; start = 1'b1; tick();
    start = 1'b0; mode = 3'd0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_total++;
    if ({q, busy, done} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL abort got q=%h busy=%b done=%b exp 00 0 0", q, busy, done);
    else n_pass++;
    tick();
    n_total++;
    if ({q, busy} !== {8'h00, 1'b0}) $display("FAIL abort_idle got q=%h busy=%b exp 00 0", q, busy);
    else n_pass++;
    load(8'h3C);
    mode = 3'd4; shamt = 4'd15; start = 1'b1; tick();
    start = 1'b0; mode = 3'd0;
    for (int i = 0; i < 7; i++) tick();
    n_total++;
    if ({busy, done} !== {1'b1, 1'b0}) $display("FAIL clamp_busy got busy=%b done=%b exp 1 0", busy, done);
    else n_pass++;
    tick();
    n_total++;
    if ({q, busy, done} !== {8'h3C, 1'b0, 1'b1})
      $display("FAIL clamp_done got q=%h busy=%b done=%b exp 3C 0 1", q, busy, done);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = 3'($urandom_range(0, 7));
      d     = 8'($urandom);
      sin_l = 1'($urandom);
      sin_r = 1'($urandom);
      start = ($urandom_range(0, 5) == 0);
      shamt = 4'($urandom_range(0, 15));
      tick();
      n_total++;
      if ({q, q_bar, sout_l, sout_r, busy, done} !==
          {m_q, ~m_q, m_q[7], m_q[0], (m_rem > 0), m_done})
        $display("FAIL random_cyc%0d got q=%h busy=%b done=%b exp q=%h busy=%b done=%b",
                 i, q, busy, done, m_q, (m_rem > 0), m_done);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_rotr_seq();
    test_stall();
    test_zero_len();
    test_abort_clamp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
